txd_arbiter: RTL and testbench

- Shares the single USB JTAG byte transmitter (oTXD_DATA/oTXD_Start/iTXD_Done) among NUM_REQ requesters: Flash, SDRAM, SRAM and PS2 readback engines.
- Replaces static output-select muxing with round-robin arbitration.
- Supports a lock that keeps the grant across multi-byte bursts (e.g. SDRAM low/high byte pair).
- Includes a watchdog so a transmitter that never answers cannot hang a requester.

---
 rtl/txd_arbiter_if.sv | 24 ++
 rtl/txd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_txd_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/txd_arbiter_if.sv
// Requester/transmitter bus for txd_arbiter: per-requester byte handshakes
// on one side, the shared USB JTAG byte transmitter on the other.
interface txd_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   iREQ_Start;
  logic [8*NUM_REQ-1:0] iREQ_DATA;
  logic [NUM_REQ-1:0]   iREQ_Lock;
  logic [NUM_REQ-1:0]   oREQ_Done;
  logic [NUM_REQ-1:0]   oGrant;
  logic [7:0]           oTXD_DATA;
  logic                 oTXD_Start;
  logic                 iTXD_Done;

  modport slave (
    input  iREQ_Start, iREQ_DATA, iREQ_Lock, iTXD_Done,
    output oREQ_Done, oGrant, oTXD_DATA, oTXD_Start
  );

  modport master (
    output iREQ_Start, iREQ_DATA, iREQ_Lock, iTXD_Done,
    input  oREQ_Done, oGrant, oTXD_DATA, oTXD_Start
  );
endinterface

// File: rtl/txd_arbiter.sv
// Round-robin arbiter sharing one USB JTAG byte transmitter among NUM_REQ
// readback engines, with burst lock, 4-phase done handshake and a watchdog.
module txd_arbiter #(
  parameter int              NUM_REQ = 4,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic          iCLK,
  input  logic          iRST_n,
  txd_arbiter_if.slave  bus,
  output logic          oBusy,
  output logic          oTO_Err,
  input  logic          iErr_Clr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_ACK,
    S_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [7:0]        data_q, data_d;
  logic              start_q, start_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [7:0]        req_byte [NUM_REQ];
  logic [IW-1:0]     rr_idx;
  logic [IW-1:0]     rr_cand;
  logic              rr_found;
  logic              timeout;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_byte[gi] = bus.iREQ_DATA[8*gi +: 8];
  end

  // Search starts just after the previous owner and wraps, so the first
  // hit is the round-robin winner.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_cand = IW'((32'(last_q) + k) % NUM_REQ);
      if (!rr_found && bus.iREQ_Start[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = done_q;
    data_d  = data_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          gidx_d          = rr_idx;
          grant_d         = '0;
          grant_d[rr_idx] = 1'b1;
          data_d          = req_byte[rr_idx];
          start_d         = 1'b1;
          cnt_d           = '0;
          state_d         = S_SEND;
        end
      end

      S_SEND: begin
        cnt_d = cnt_q + 1'b1;
        // Done takes priority over an expiring watchdog on the same cycle.
        if (bus.iTXD_Done || (cnt_q == TO_LAST)) begin
          timeout        = !bus.iTXD_Done;
          start_d        = 1'b0;
          done_d         = '0;
          done_d[gidx_q] = 1'b1;
          state_d        = S_ACK;
        end
      end

      S_ACK: begin
        if (!bus.iREQ_Start[gidx_q]) begin
          done_d = '0;
          if (bus.iREQ_Lock[gidx_q]) begin
            state_d = S_LOCKED;
          end else begin
            last_d  = gidx_q;
            grant_d = '0;
            state_d = S_IDLE;
          end
        end
      end

      S_LOCKED: begin
        if (bus.iREQ_Start[gidx_q]) begin
          data_d  = req_byte[gidx_q];
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_SEND;
        end else if (!bus.iREQ_Lock[gidx_q]) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        done_d  = '0;
        start_d = 1'b0;
      end
    endcase

    err_d = err_q;
    if (iErr_Clr) err_d = 1'b0;
    if (timeout)  err_d = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      data_q  <= data_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.oGrant     = grant_q;
  assign bus.oREQ_Done  = done_q;
  assign bus.oTXD_DATA  = data_q;
  assign bus.oTXD_Start = start_q;
  assign oBusy          = (state_q != S_IDLE);
  assign oTO_Err        = err_q;

endmodule

// File: tb/tb_txd_arbiter.sv
// Randomised bench for txd_arbiter: requester tasks and a transmitter model
// drive the bus; a monitor checks each launched byte against a queue of
// expected (requester, byte) pairs built from a transaction-level model.
module tb_txd_arbiter;
  localparam int NR  = 4;
  localparam int TO  = 8;
  localparam int LIM = 3000;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic iCLK     = 1'b0;
  logic iRST_n   = 1'b0;
  logic iErr_Clr = 1'b0;
  logic oBusy;
  logic oTO_Err;

  logic       st_a [NR];
  logic       lk_a [NR];
  logic [7:0] dt_a [NR];
  logic       tx_done   = 1'b0;
  logic       idle_done = 1'b0;
  bit         tx_en     = 1'b1;
  int         tx_fix    = -1;
  int         tx_d;
  logic       tx_prev   = 1'b0;
  logic       mon_prev  = 1'b0;
  logic [7:0] mon_held  = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   m_last = NR - 1;
  int   m_t, m_hi;

  int         sc_n    [NR];
  logic [7:0] sc_data [NR][4];
  bit         sc_lock [NR];

  txd_arbiter_if #(.NUM_REQ(NR)) bus ();

  txd_arbiter #(
    .NUM_REQ(NR),
    .TO_W   (16),
    .TIMEOUT(16'(TO))
  ) dut (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .bus     (bus),
    .oBusy   (oBusy),
    .oTO_Err (oTO_Err),
    .iErr_Clr(iErr_Clr)
  );

  always #5 iCLK = ~iCLK;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      bus.iREQ_Start[i]       = st_a[i];
      bus.iREQ_Lock[i]        = lk_a[i];
      bus.iREQ_DATA[8*i +: 8] = dt_a[i];
    end
    bus.iTXD_Done = tx_done | idle_done;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound of %0d cycles expired at %0t", name, LIM, $time);
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Transaction-level reference: every pending requester is served in
  // round-robin order after the last owner; a locked requester sends its
  // whole burst before anyone else is considered.
  task automatic model_scenario();
    int  rem [NR];
    int  pos [NR];
    int  w;
    int  c;
    for (int i = 0; i < NR; i++) begin
      rem[i] = sc_n[i];
      pos[i] = 0;
    end
    do begin
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (w < 0 && rem[c] > 0) w = c;
      end
      if (w >= 0) begin
        do begin
          exp_q.push_back('{idx: w, data: sc_data[w][pos[w]]});
          pos[w]++;
          rem[w]--;
        end while (sc_lock[w] && rem[w] > 0);
        m_last = w;
      end
    end while (w >= 0);
  endtask

  task automatic run_req(input int i);
    int t;
    int hold;
    for (int b = 0; b < sc_n[i]; b++) begin
      dt_a[i] = sc_data[i][b];
      lk_a[i] = sc_lock[i];
      st_a[i] = 1'b1;
      t = 0;
      while (!(bus.oGrant[i] && bus.oTXD_Start) && t < LIM) begin
        @(negedge iCLK);
        t++;
      end
      if (t >= LIM) begin
        fail_bound("launch_wait");
        st_a[i] = 1'b0;
        lk_a[i] = 1'b0;
        return;
      end
      dt_a[i] = 8'($urandom);
      t = 0;
      while (!bus.oREQ_Done[i] && t < LIM) begin
        @(negedge iCLK);
        t++;
      end
      if (t >= LIM) begin
        fail_bound("done_wait");
        st_a[i] = 1'b0;
        lk_a[i] = 1'b0;
        return;
      end
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge iCLK);
        check("done_hold", 32'(bus.oREQ_Done[i]), 32'd1);
      end
      st_a[i] = 1'b0;
      @(negedge iCLK);
      check("done_clr", 32'(bus.oREQ_Done), 32'd0);
      if (!sc_lock[i]) check("grant_rel", 32'(bus.oGrant), 32'd0);
      else             check("grant_kept", 32'(bus.oGrant), 32'(oh(i)));
      if (b + 1 < sc_n[i]) repeat ($urandom_range(0, 1)) @(negedge iCLK);
    end
    if (sc_lock[i] && sc_n[i] > 0) begin
      repeat ($urandom_range(0, 3)) @(negedge iCLK);
      lk_a[i] = 1'b0;
    end
  endtask

  task automatic clear_sc();
    for (int i = 0; i < NR; i++) begin
      sc_n[i]    = 0;
      sc_lock[i] = 1'b0;
      for (int b = 0; b < 4; b++) sc_data[i][b] = '0;
    end
  endtask

  task automatic run_scenario();
    int t;
    model_scenario();
    fork
      run_req(0);
      run_req(1);
      run_req(2);
      run_req(3);
    join
    t = 0;
    while (oBusy && t < LIM) begin
      @(negedge iCLK);
      t++;
    end
    if (t >= LIM) fail_bound("idle_wait");
    check("exp_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Transmitter model: answers each new oTXD_Start after a delay unless disabled.
  initial begin
    forever begin
      @(negedge iCLK);
      if (bus.oTXD_Start && !tx_prev && tx_en) begin
        tx_d = (tx_fix >= 0) ? tx_fix : $urandom_range(0, 5);
        repeat (tx_d) @(negedge iCLK);
        tx_done = 1'b1;
        @(negedge iCLK);
        tx_done = 1'b0;
      end
      tx_prev = bus.oTXD_Start;
    end
  end

  // Monitor: pops one expectation per launched byte and checks invariants.
  always @(negedge iCLK) begin
    exp_t e;
    check("grant_onehot", 32'($onehot0(bus.oGrant)), 32'd1);
    check("done_in_grant", 32'(bus.oREQ_Done & ~bus.oGrant), 32'd0);
    check("start_busy", 32'(bus.oTXD_Start & ~oBusy), 32'd0);
    if (bus.oTXD_Start && !mon_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL launch_unexpected: got grant %0h data %0h expected none", bus.oGrant, bus.oTXD_DATA);
      end else begin
        e = exp_q.pop_front();
        check("launch_grant", 32'(bus.oGrant), 32'(oh(e.idx)));
        check("launch_data", 32'(bus.oTXD_DATA), 32'(e.data));
      end
      mon_held = bus.oTXD_DATA;
    end else if (bus.oTXD_Start) begin
      check("data_stable", 32'(bus.oTXD_DATA), 32'(mon_held));
    end
    mon_prev = bus.oTXD_Start;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      st_a[i] = 1'b0;
      lk_a[i] = 1'b0;
      dt_a[i] = '0;
    end
    repeat (3) @(negedge iCLK);
    check("rst_grant", 32'(bus.oGrant), 32'd0);
    check("rst_done", 32'(bus.oREQ_Done), 32'd0);
    check("rst_start", 32'(bus.oTXD_Start), 32'd0);
    check("rst_data", 32'(bus.oTXD_DATA), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_err", 32'(oTO_Err), 32'd0);
    iRST_n = 1'b1;
    @(negedge iCLK);

    // contention from reset; requester 0 comes back right after release
    clear_sc();
    sc_n[0] = 2; sc_data[0][0] = 8'h10; sc_data[0][1] = 8'h11;
    sc_n[1] = 1; sc_data[1][0] = 8'h21;
    sc_n[2] = 1; sc_data[2][0] = 8'h32;
    sc_n[3] = 1; sc_data[3][0] = 8'h43;
    run_scenario();

    // locked burst from requester 1 while requester 2 waits
    clear_sc();
    sc_n[1] = 2; sc_lock[1] = 1'b1; sc_data[1][0] = 8'h34; sc_data[1][1] = 8'h12;
    sc_n[2] = 1; sc_data[2][0] = 8'h77;
    run_scenario();

    // single request
    clear_sc();
    sc_n[1] = 1; sc_data[1][0] = 8'hA5;
    run_scenario();

    for (int s = 0; s < 25; s++) begin
      clear_sc();
      for (int i = 0; i < NR; i++) begin
        sc_n[i]    = $urandom_range(0, 3);
        sc_lock[i] = ($urandom_range(0, 2) == 0);
        for (int b = 0; b < 4; b++) sc_data[i][b] = 8'($urandom);
      end
      if (sc_n[0] + sc_n[1] + sc_n[2] + sc_n[3] == 0) sc_n[s % NR] = 1;
      run_scenario();
    end

    // watchdog expiry: transmitter silent
    tx_en = 1'b0;
    clear_sc();
    sc_n[2] = 1; sc_data[2][0] = 8'h5A;
    model_scenario();
    fork
      run_req(2);
      begin
        m_t = 0;
        while (!bus.oTXD_Start && m_t < LIM) begin
          @(negedge iCLK);
          m_t++;
        end
        m_hi = 0;
        while (bus.oTXD_Start && m_hi < LIM) begin
          @(negedge iCLK);
          m_hi++;
        end
        check("to_len", 32'(m_hi), 32'(TO));
      end
    join
    check("to_err_set", 32'(oTO_Err), 32'd1);
    iErr_Clr = 1'b1;
    @(negedge iCLK);
    iErr_Clr = 1'b0;
    check("to_err_clr", 32'(oTO_Err), 32'd0);

    // clear asserted on the very cycle the watchdog fires
    clear_sc();
    sc_n[1] = 1; sc_data[1][0] = 8'h6B;
    model_scenario();
    fork
      run_req(1);
      begin
        m_t = 0;
        while (!bus.oTXD_Start && m_t < LIM) begin
          @(negedge iCLK);
          m_t++;
        end
        repeat (TO - 1) @(negedge iCLK);
        iErr_Clr = 1'b1;
        @(negedge iCLK);
        iErr_Clr = 1'b0;
        check("to_set_wins", 32'(oTO_Err), 32'd1);
      end
    join
    iErr_Clr = 1'b1;
    @(negedge iCLK);
    iErr_Clr = 1'b0;
    check("to_err_clr2", 32'(oTO_Err), 32'd0);

    // Done arrives on the same cycle the watchdog would fire
    tx_en  = 1'b1;
    tx_fix = TO - 1;
    clear_sc();
    sc_n[3] = 1; sc_data[3][0] = 8'h3C;
    run_scenario();
    check("done_wins", 32'(oTO_Err), 32'd0);
    tx_fix = -1;

    // Done while idle
    idle_done = 1'b1;
    @(negedge iCLK);
    idle_done = 1'b0;
    check("idle_done_busy", 32'(oBusy), 32'd0);
    check("idle_done_grant", 32'(bus.oGrant), 32'd0);
    check("idle_done_start", 32'(bus.oTXD_Start), 32'd0);
    check("idle_done_done", 32'(bus.oREQ_Done), 32'd0);

    // reset in the middle of a SEND
    tx_en = 1'b0;
    exp_q.push_back('{idx: 2, data: 8'hC3});
    dt_a[2] = 8'hC3;
    st_a[2] = 1'b1;
    m_t = 0;
    while (!bus.oTXD_Start && m_t < LIM) begin
      @(negedge iCLK);
      m_t++;
    end
    if (m_t >= LIM) fail_bound("rst_launch_wait");
    repeat (2) @(negedge iCLK);
    iRST_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(bus.oGrant), 32'd0);
    check("mid_rst_start", 32'(bus.oTXD_Start), 32'd0);
    check("mid_rst_done", 32'(bus.oREQ_Done), 32'd0);
    check("mid_rst_data", 32'(bus.oTXD_DATA), 32'd0);
    check("mid_rst_busy", 32'(oBusy), 32'd0);
    st_a[2] = 1'b0;
    @(negedge iCLK);
    iRST_n = 1'b1;
    m_last = NR - 1;
    tx_en  = 1'b1;
    @(negedge iCLK);

    clear_sc();
    sc_n[3] = 1; sc_data[3][0] = 8'hD3;
    sc_n[0] = 1; sc_data[0][0] = 8'hD0;
    run_scenario();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
